// File: rtl/sfu_ctrl.sv
// Sequencer for the SFU: accumulates n_pass passes of psum rows from the output FIFO,
// then runs one relu pass over the psum memory, with a 2-stage write-back pipeline.
module sfu_ctrl #(
    parameter int ADDR_BW = 6,
    parameter int PASS_BW = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_BW-1:0] n_rows,
    input  logic [PASS_BW-1:0] n_pass,
    input  logic               ofifo_valid,
    output logic               acc,
    output logic               relu,
    output logic               first_pass,
    output logic               ofifo_rd,
    output logic               psum_mem_rd,
    output logic [ADDR_BW-1:0] psum_mem_rd_addr,
    output logic               psum_mem_wr,
    output logic [ADDR_BW-1:0] psum_mem_wr_addr,
    output logic               busy,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_ADRAIN,
        S_RELU,
        S_RDRAIN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_BW-1:0] row_cnt_q, row_cnt_d;
    logic [PASS_BW:0]   pass_cnt_q, pass_cnt_d;
    logic [ADDR_BW-1:0] n_rows_q, n_rows_d;
    logic [PASS_BW-1:0] n_pass_q, n_pass_d;
    logic               drain_q, drain_d;
    logic               p1_vld_q, p1_vld_d;
    logic [ADDR_BW-1:0] p1_addr_q, p1_addr_d;
    logic               p2_vld_q, p2_vld_d;
    logic [ADDR_BW-1:0] p2_addr_q, p2_addr_d;

    logic [ADDR_BW-1:0] last_row;
    logic [PASS_BW:0]   pass_next;
    logic               at_last_row;

    assign last_row    = n_rows_q - ADDR_BW'(1);
    assign at_last_row = (row_cnt_q == last_row);
    assign pass_next   = pass_cnt_q + (PASS_BW+1)'(1);

    always_comb begin
        state_d          = state_q;
        row_cnt_d        = row_cnt_q;
        pass_cnt_d       = pass_cnt_q;
        n_rows_d         = n_rows_q;
        n_pass_d         = n_pass_q;
        drain_d          = drain_q;
        acc              = 1'b0;
        relu             = 1'b0;
        first_pass       = 1'b0;
        ofifo_rd         = 1'b0;
        psum_mem_rd      = 1'b0;
        psum_mem_rd_addr = '0;
        done             = 1'b0;
        busy             = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_rows_d   = n_rows;
                    n_pass_d   = n_pass;
                    row_cnt_d  = '0;
                    pass_cnt_d = '0;
                    drain_d    = 1'b0;
                    if (n_rows == '0 || n_pass == '0) state_d = S_DONE;
                    else                              state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc        = 1'b1;
                first_pass = (pass_cnt_q == '0);
                if (ofifo_valid) begin
                    ofifo_rd         = 1'b1;
                    psum_mem_rd      = 1'b1;
                    psum_mem_rd_addr = row_cnt_q;
                    if (at_last_row) begin
                        row_cnt_d = '0;
                        state_d   = S_ADRAIN;
                    end else begin
                        row_cnt_d = row_cnt_q + ADDR_BW'(1);
                    end
                end
            end
            S_ADRAIN: begin
                // Still pass k here: the writes landing now belong to this pass.
                acc        = 1'b1;
                first_pass = (pass_cnt_q == '0);
                drain_d    = ~drain_q;
                if (drain_q) begin
                    pass_cnt_d = pass_next;
                    if (pass_next < {1'b0, n_pass_q}) state_d = S_ACC;
                    else                              state_d = S_RELU;
                end
            end
            S_RELU: begin
                relu             = 1'b1;
                psum_mem_rd      = 1'b1;
                psum_mem_rd_addr = row_cnt_q;
                if (at_last_row) begin
                    row_cnt_d = '0;
                    state_d   = S_RDRAIN;
                end else begin
                    row_cnt_d = row_cnt_q + ADDR_BW'(1);
                end
            end
            S_RDRAIN: begin
                relu    = 1'b1;
                drain_d = ~drain_q;
                if (drain_q) state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        p1_vld_d  = psum_mem_rd;
        p1_addr_d = psum_mem_rd_addr;
        p2_vld_d  = p1_vld_q;
        p2_addr_d = p1_addr_q;
    end

    assign psum_mem_wr      = p2_vld_q;
    assign psum_mem_wr_addr = p2_addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            row_cnt_q  <= '0;
            pass_cnt_q <= '0;
            n_rows_q   <= '0;
            n_pass_q   <= '0;
            drain_q    <= 1'b0;
            p1_vld_q   <= 1'b0;
            p1_addr_q  <= '0;
            p2_vld_q   <= 1'b0;
            p2_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            n_rows_q   <= n_rows_d;
            n_pass_q   <= n_pass_d;
            drain_q    <= drain_d;
            p1_vld_q   <= p1_vld_d;
            p1_addr_q  <= p1_addr_d;
            p2_vld_q   <= p2_vld_d;
            p2_addr_q  <= p2_addr_d;
        end
    end

endmodule
